// File: rtl/cvmcu_probe_stim_pkg.sv
// cvmcu_probe_stim_pkg: shared types and defaults for the probe stimulus driver
package cvmcu_probe_stim_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DLY_W_DEF  = 16;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [DATA_W_DEF-1:0] mask;
        logic [DLY_W_DEF-1:0]  dly;
    } entry_t;

endpackage

// File: rtl/cvmcu_probe_stim_drv_if.sv
// cvmcu_probe_stim_drv_if: valid/ready stimulus entry channel (data, mask, delay)
interface cvmcu_probe_stim_drv_if
    import cvmcu_probe_stim_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DLY_W  = DLY_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_data;
    logic [DATA_W-1:0] req_mask;
    logic [DLY_W-1:0]  req_dly;

    modport master (output req_valid, req_data, req_mask, req_dly, input req_ready);
    modport slave  (input req_valid, req_data, req_mask, req_dly, output req_ready);
endinterface

// File: rtl/cvmcu_probe_stim_fifo.sv
// cvmcu_probe_stim_fifo: small synchronous FIFO with flush and full/empty flags
module cvmcu_probe_stim_fifo
    import cvmcu_probe_stim_pkg::*;
#(
    parameter type T     = entry_t,
    parameter int  DEPTH = DEPTH_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_flush,
    input  logic i_push,
    input  logic i_pop,
    input  T     i_data,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    T            r_mem [DEPTH];

    // Pointers carry one wrap bit so full and empty are distinguishable; flush drops everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + (AW+1)'(1);
            if (i_pop)  r_rd <= r_rd + (AW+1)'(1);
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (i_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rd[AW-1:0]];
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
endmodule

// File: rtl/cvmcu_probe_stim_drv.sv
// cvmcu_probe_stim_drv: plays queued (data, mask, delay) entries onto probe outputs in order.
// Optional CVMCU_PROBE_STIM_TIMESTAMP_EN adds apply_ts_o, the free-running cycle count at the last apply.
module cvmcu_probe_stim_drv
    import cvmcu_probe_stim_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DLY_W  = DLY_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    cvmcu_probe_stim_drv_if.slave req,
    output logic [DATA_W-1:0]     probe_o,
    output logic [DATA_W-1:0]     probe_oe_o,
    output logic                  applied_o,
`ifdef CVMCU_PROBE_STIM_TIMESTAMP_EN
    output logic [31:0]           apply_ts_o,
`endif
    output logic                  busy_o
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
        logic [DLY_W-1:0]  dly;
    } entry_p_t;

    entry_p_t          w_in;
    entry_p_t          w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_apply;
    logic              w_full;
    logic              w_empty;
    state_t            w_state_nxt;
    logic [DLY_W-1:0]  w_cnt_nxt;
    state_t            r_state;
    logic [DLY_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r_probe;
    logic [DATA_W-1:0] r_oe;
    logic              r_applied;

    assign req.req_ready = !w_full && !flush_i;
    assign w_push        = req.req_valid && req.req_ready;
    assign w_in          = {req.req_data, req.req_mask, req.req_dly};

    cvmcu_probe_stim_fifo #(
        .T     (entry_p_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_flush (flush_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next state: pop into WAIT, count down, apply at zero and chain straight into the next entry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_apply     = 1'b0;
        if (flush_i) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (r_state == IDLE) begin
            w_pop       = !w_empty;
            w_cnt_nxt   = w_empty ? r_cnt : w_head.dly;
            w_state_nxt = w_empty ? IDLE : WAIT;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - DLY_W'(1);
        end else begin
            w_apply     = 1'b1;
            w_pop       = !w_empty;
            w_cnt_nxt   = w_empty ? '0 : w_head.dly;
            w_state_nxt = w_empty ? IDLE : WAIT;
        end
    end

    // State, countdown, latched entry and the sticky probe drive registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_data    <= '0;
            r_mask    <= '0;
            r_probe   <= '0;
            r_oe      <= '0;
            r_applied <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_applied <= w_apply;
            if (flush_i) begin
                r_data <= '0;
                r_mask <= '0;
            end else if (w_pop) begin
                r_data <= w_head.data;
                r_mask <= w_head.mask;
            end
            if (w_apply) begin
                r_probe <= (r_probe & ~r_mask) | (r_data & r_mask);
                r_oe    <= r_oe | r_mask;
            end
        end
    end

    assign probe_o    = r_probe;
    assign probe_oe_o = r_oe;
    assign applied_o  = r_applied;
    assign busy_o     = !w_empty || (r_state == WAIT);

`ifdef CVMCU_PROBE_STIM_TIMESTAMP_EN
    logic [31:0] r_cyc;
    logic [31:0] r_ts;

    // Free-running cycle counter; its value is captured on every apply edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cyc <= '0;
            r_ts  <= '0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (w_apply) r_ts <= r_cyc;
        end
    end

    assign apply_ts_o = r_ts;
`endif
endmodule

// File: tb/tb_cvmcu_probe_stim_drv.sv
// tb_cvmcu_probe_stim_drv: directed vectors for the probe stimulus driver
module tb_cvmcu_probe_stim_drv;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic [31:0] probe_o;
    logic [31:0] probe_oe_o;
    logic        applied_o;
    logic        busy_o;
`ifdef CVMCU_PROBE_STIM_TIMESTAMP_EN
    logic [31:0] apply_ts_o;
`endif
    int          n_vec = 0;
    int          n_err = 0;

    cvmcu_probe_stim_drv_if #(.DATA_W(32), .DLY_W(16)) req_if ();

    cvmcu_probe_stim_drv dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .req        (req_if),
        .probe_o    (probe_o),
        .probe_oe_o (probe_oe_o),
        .applied_o  (applied_o),
`ifdef CVMCU_PROBE_STIM_TIMESTAMP_EN
        .apply_ts_o (apply_ts_o),
`endif
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] m, input logic [15:0] dl);
        req_if.req_data  = d;
        req_if.req_mask  = m;
        req_if.req_dly   = dl;
        req_if.req_valid = 1'b1;
        for (int i = 0; i < 100 && !req_if.req_ready; i++) tick();
        chk("push_ready", 32'(req_if.req_ready), 32'd1);
        tick();
        req_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy_o; i++) tick();
        chk("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        int          n_push;
        int          n_app;
        int          blk_at;
        int          app1_cyc;
        int          rdy_back;
        int          pulses;
        logic        acc;
        logic [3:0]  exp_p [6];
        logic        exp_a [6];
        exp_p = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
        exp_a = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rst_ni           = 1'b0;
        flush_i          = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_data  = '0;
        req_if.req_mask  = '0;
        req_if.req_dly   = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_probe", probe_o, 32'h0);
        chk("rst_oe", probe_oe_o, 32'h0);
        chk("rst_applied", 32'(applied_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(req_if.req_ready), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // single entry, dly=3: outputs change at push edge + 5
        push(32'hA5A5_0000, 32'hFFFF_0000, 16'd3);
        chk("t1_busy", 32'(busy_o), 32'd1);
        repeat (4) tick();
        chk("t1_early_probe", probe_o, 32'h0);
        chk("t1_early_app", 32'(applied_o), 32'd0);
        tick();
        chk("t1_probe", probe_o, 32'hA5A5_0000);
        chk("t1_oe", probe_oe_o, 32'hFFFF_0000);
        chk("t1_app", 32'(applied_o), 32'd1);
        tick();
        chk("t1_app_drop", 32'(applied_o), 32'd0);
        chk("t1_idle", 32'(busy_o), 32'd0);

        // four dly=0 entries on consecutive edges
        for (int i = 0; i < 6; i++) begin
            req_if.req_valid = (i < 4);
            req_if.req_data  = 32'hFFFF_FFFF;
            req_if.req_mask  = 32'd1 << i;
            req_if.req_dly   = 16'd0;
            tick();
            chk($sformatf("t2_probe%0d", i), 32'(probe_o[3:0]), 32'(exp_p[i]));
            chk($sformatf("t2_app%0d", i), 32'(applied_o), 32'(exp_a[i]));
            chk($sformatf("t2_busy%0d", i), 32'(busy_o), (i == 5) ? 32'd0 : 32'd1);
        end
        req_if.req_valid = 1'b0;

        // six entries with valid held, dly=10: backpressure and ordering
        cyc = 0; n_push = 0; n_app = 0; blk_at = -1; app1_cyc = -1; rdy_back = -1;
        req_if.req_mask = 32'hFF;
        req_if.req_dly  = 16'd10;
        while (n_app < 6 && cyc < 200) begin
            req_if.req_valid = (n_push < 6);
            req_if.req_data  = 32'(n_push + 1);
            acc = req_if.req_valid && req_if.req_ready;
            if (!req_if.req_ready && blk_at < 0) blk_at = n_push;
            if (req_if.req_ready && blk_at >= 0 && rdy_back < 0) rdy_back = cyc;
            tick();
            cyc++;
            if (acc) n_push++;
            if (applied_o) begin
                chk("t3_order", 32'(probe_o[7:0]), 32'(n_app + 1));
                if (app1_cyc < 0) app1_cyc = cyc;
                n_app++;
            end
        end
        req_if.req_valid = 1'b0;
        chk("t3_blocked_at", 32'(blk_at), 32'd5);
        chk("t3_first_apply", 32'(app1_cyc), 32'd13);
        chk("t3_ready_back", 32'(rdy_back), 32'(app1_cyc));
        chk("t3_pushed", 32'(n_push), 32'd6);
        chk("t3_applied", 32'(n_app), 32'd6);
        chk("t3_idle", 32'(busy_o), 32'd0);

        // overlapping masks
        push(32'h0000_0012, 32'h0000_00FF, 16'd0);
        push(32'h0000_0304, 32'h0000_0F0F, 16'd0);
        wait_idle();
        chk("t4_probe", probe_o, 32'hA5A5_0314);
        chk("t4_oe", probe_oe_o, 32'hFFFF_0FFF);

        // flush while waiting with cnt=5 and two entries queued
        push(32'hDEAD_BEEF, 32'hFFFF_FFFF, 16'd20);
        push(32'h1111_1111, 32'hFFFF_FFFF, 16'd0);
        push(32'h2222_2222, 32'hFFFF_FFFF, 16'd0);
        repeat (14) tick();
        flush_i = 1'b1;
        #1;
        chk("t5_ready_flush", 32'(req_if.req_ready), 32'd0);
        tick();
        flush_i = 1'b0;
        chk("t5_busy", 32'(busy_o), 32'd0);
        chk("t5_app", 32'(applied_o), 32'd0);
        chk("t5_probe", probe_o, 32'hA5A5_0314);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (applied_o) pulses++;
        end
        chk("t5_no_apply", 32'(pulses), 32'd0);
        push(32'h1234_5678, 32'hFFFF_FFFF, 16'd1);
        tick();
        tick();
        chk("t5_post_early", 32'(applied_o), 32'd0);
        tick();
        chk("t5_post_app", 32'(applied_o), 32'd1);
        chk("t5_post_probe", probe_o, 32'h1234_5678);
        chk("t5_post_oe", probe_oe_o, 32'hFFFF_FFFF);
        tick();

        // asynchronous reset in the middle of a wait
        push(32'h0, 32'h0000_FFFF, 16'd50);
        repeat (10) tick();
        chk("t6_pre_probe", probe_o, 32'h1234_5678);
        chk("t6_pre_busy", 32'(busy_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_probe", probe_o, 32'h0);
        chk("t6_oe", probe_oe_o, 32'h0);
        chk("t6_app", 32'(applied_o), 32'd0);
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_ready", 32'(req_if.req_ready), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // first push on edge 1 after reset, applied on edge 101 (counter reads 100 there)
        push(32'hCAFE_0000, 32'hFFFF_0000, 16'd98);
        repeat (99) tick();
        chk("t7_early_app", 32'(applied_o), 32'd0);
        chk("t7_early_probe", probe_o, 32'h0);
        tick();
        chk("t7_app", 32'(applied_o), 32'd1);
        chk("t7_probe", probe_o, 32'hCAFE_0000);
`ifdef CVMCU_PROBE_STIM_TIMESTAMP_EN
        chk("t7_ts", apply_ts_o, 32'd100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
